// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM and hh:mm:ss:xx binary timekeeping cascade.
// Optional macro STOPWATCH_BTN_EDGE_EN: buttons are levels, edge-detected.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   tick_100hz          one-clk 100 Hz count enable
//   btn_start/lap/clr   front-panel requests
//   hours..centisec     registered display time (live or lap hold)
//   running             state is RUN or LAP
//   lap_active          state is LAP (display frozen)
//   ovf                 sticky hours-wrap flag
module stopwatch_ctrl #(
  parameter int HOUR_MAX = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_100hz,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic [7:0] centisec,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);

  localparam logic [7:0] LP_HMAX = 8'(HOUR_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_PAUSE
  } state_t;

  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] mn;
    logic [7:0] sc;
    logic [7:0] cs;
  } tod_t;

  state_t r_state;
  state_t w_state_nxt;
  tod_t   r_live;
  tod_t   r_hold;
  tod_t   r_disp;
  logic   r_ovf;

  tod_t   w_live_nxt;
  tod_t   w_hold_nxt;
  logic   w_ovf_nxt;
  logic   w_capture;
  logic   w_clear;
  logic   w_cnt;
  logic   w_hr_wrap;
  logic [2:0] w_req;
  logic   w_start;
  logic   w_lap;
  logic   w_clr;

`ifdef STOPWATCH_BTN_EDGE_EN
  logic [2:0] r_btn_q;
  logic [2:0] r_btn_prev;

  // Both stages reset high so a button held across
  // reset release never looks like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_q    <= 3'b111;
      r_btn_prev <= 3'b111;
    end else begin
      r_btn_q    <= {btn_clr, btn_lap, btn_start};
      r_btn_prev <= r_btn_q;
    end
  end

  assign w_req = r_btn_q & ~r_btn_prev;
`else
  assign w_req = {btn_clr, btn_lap, btn_start};
`endif

  assign w_start = w_req[0];
  assign w_lap   = w_req[1];
  assign w_clr   = w_req[2];

  // Each state tests only the requests it honours, in
  // clr > start > lap order, so an ignored higher
  // request never masks a valid lower one.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_start) begin
          w_state_nxt = S_PAUSE;
        end else if (w_lap) begin
          w_state_nxt = S_LAP;
          w_capture   = 1'b1;
        end
      end
      S_LAP: begin
        if (w_start)    w_state_nxt = S_PAUSE;
        else if (w_lap) w_state_nxt = S_RUN;
      end
      S_PAUSE: begin
        if (w_clr) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end else if (w_start) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counting keys off the registered state only.
  assign w_cnt = tick_100hz &
                 ((r_state == S_RUN) ||
                  (r_state == S_LAP));

  assign w_hr_wrap = (r_live.cs == 8'd99) &&
                     (r_live.sc == 8'd59) &&
                     (r_live.mn == 8'd59) &&
                     (r_live.hr == LP_HMAX);

  always_comb begin
    w_live_nxt = r_live;
    if (w_clear) begin
      w_live_nxt = '0;
    end else if (w_cnt) begin
      if (r_live.cs != 8'd99) begin
        w_live_nxt.cs = r_live.cs + 8'd1;
      end else begin
        w_live_nxt.cs = 8'd0;
        if (r_live.sc != 8'd59) begin
          w_live_nxt.sc = r_live.sc + 8'd1;
        end else begin
          w_live_nxt.sc = 8'd0;
          if (r_live.mn != 8'd59) begin
            w_live_nxt.mn = r_live.mn + 8'd1;
          end else begin
            w_live_nxt.mn = 8'd0;
            if (r_live.hr != LP_HMAX)
              w_live_nxt.hr = r_live.hr + 8'd1;
            else
              w_live_nxt.hr = 8'd0;
          end
        end
      end
    end
  end

  // Hold takes the pre-increment live value.
  always_comb begin
    w_hold_nxt = r_hold;
    if (w_clear)        w_hold_nxt = '0;
    else if (w_capture) w_hold_nxt = r_live;
  end

  always_comb begin
    w_ovf_nxt = r_ovf;
    if (w_clear)                w_ovf_nxt = 1'b0;
    else if (w_cnt && w_hr_wrap) w_ovf_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= '0;
      r_hold  <= '0;
      r_disp  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= w_live_nxt;
      r_hold  <= w_hold_nxt;
      r_ovf   <= w_ovf_nxt;
      r_disp  <= (w_state_nxt == S_LAP) ?
                 w_hold_nxt : w_live_nxt;
    end
  end

  assign hours      = r_disp.hr;
  assign minutes    = r_disp.mn;
  assign seconds    = r_disp.sc;
  assign centisec   = r_disp.cs;
  assign running    = (r_state == S_RUN) ||
                      (r_state == S_LAP);
  assign lap_active = (r_state == S_LAP);
  assign ovf        = r_ovf;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control and timekeeping core of the digital stopwatch.
- Runs a start/stop/lap/clear state machine from front-panel button pulses.
- Advances a BCD-free binary hh:mm:ss:xx counter cascade on a 100 Hz enable.
- Presents either live or frozen-lap time to the 7-segment display driver.

Parameters:
- HOUR_MAX, 99, largest hours value; the cascade wraps from HOUR_MAX:59:59:99 to 00:00:00:00 (legal range 1..99).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tick_100hz  in  1  one-clk-wide enable pulse, 100 Hz
- btn_start  in  1  start/stop request
- btn_lap  in  1  lap/split request
- btn_clr  in  1  clear request
- hours  out  8  displayed hours, binary 0..HOUR_MAX
- minutes  out  8  displayed minutes, binary 0..59
- seconds  out  8  displayed seconds, binary 0..59
- centisec  out  8  displayed centiseconds, binary 0..99
- running  out  1  high in RUN or LAP
- lap_active  out  1  high in LAP (display frozen)
- ovf  out  1  sticky, set on hours wrap

Behaviour:
- Interface: single clock clk. Reset rst_n is asynchronous assert, active-low. All registers and outputs go to 0 on reset, and the state goes to IDLE.
- States: IDLE, RUN, LAP, PAUSE.
- Request priority per cycle: clr > start > lap. Only the highest-priority valid request is acted on; the others are dropped.
- IDLE:
  - start -> RUN.
  - lap and clr: no effect (counters already 0).
- RUN:
  - start -> PAUSE.
  - lap -> LAP; live counters are copied into the hold registers in the same cycle.
  - clr is ignored while running.
- LAP:
  - Counting continues and the display shows the hold registers.
  - lap -> RUN, and the display returns to live.
  - start -> PAUSE, and the display returns to live.
  - clr is ignored.
- PAUSE:
  - start -> RUN.
  - clr -> IDLE; live counters, hold registers and ovf are zeroed.
  - lap is ignored.
- Counting rule: the cascade advances only when tick_100hz=1 and the *current* (registered) state is RUN or LAP.
  - A tick in the same cycle as start-from-IDLE/PAUSE is not counted.
  - A tick in the same cycle as start-from-RUN/LAP (stop) is counted.
  - A tick in the same cycle as a lap capture is counted in live. The hold registers take the pre-increment value.
- Cascade:
  - centisec 99 -> 0 with carry to seconds.
  - seconds 59 -> 0 with carry to minutes.
  - minutes 59 -> 0 with carry to hours.
  - hours HOUR_MAX -> 0 sets ovf.
  - All carries resolve in the same clock. Counters never take values outside their ranges.
- Outputs:
  - hours/minutes/seconds/centisec are registered: the value selected by the next state and the next counter values appears one clk after the event.
  - running and lap_active are decoded from the registered state.
- ovf: sticky. It is cleared only by reset or by clr in PAUSE.
- Reset mid-count or mid-lap: immediate return to IDLE with zeros. No request is remembered.
- Inputs are assumed synchronous to clk and already debounced.

Optional Feature:
- Macro: STOPWATCH_BTN_EDGE_EN.
- Defined:
  - btn_start, btn_lap and btn_clr are held levels.
  - The block registers each one and acts only on a 0->1 transition, adding 1 clk of latency.
  - The previous-value registers reset to 1, so a button already held at reset release does not trigger.
  - Holding a button high gives exactly one request.
- Undefined:
  - Inputs are single-clk pulses. Every cycle a button is high counts as a request, with no extra latency.

Test Plan:
- Reset, then start, then 150 ticks -> outputs 00:00:01:50, running=1; a start pulse on the same cycle as the first tick does not count it.
- Counter at 00:00:59:99 in RUN, one tick -> 00:01:00:00 one clk later.
- HOUR_MAX=99, preload via ticks/forced counters to 99:59:59:99, one tick -> 00:00:00:00, ovf=1. Then stop, clr -> IDLE, ovf=0, all zeros.
- RUN at 00:00:02:00, lap:
  - display frozen at 00:00:02:00 for 300 further ticks, lap_active=1;
  - second lap -> display shows live 00:00:05:00.
- In RUN, btn_clr+btn_start in the same cycle -> clr ignored, start acts -> PAUSE with counters preserved. In PAUSE, clr+start together -> IDLE, zeros.
- With STOPWATCH_BTN_EDGE_EN: hold btn_start high 50 clks -> one RUN transition only. Button high through reset release -> no transition.
